// File: rtl/restoring_divider_16_bit.sv
// Iterative 16-bit unsigned restoring divider, one quotient bit per clock.
// Trial subtraction uses a 16-bit carry-lookahead adder (R + ~D + 1).
module restoring_divider_16_bit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start_In,
  input  logic [15:0] Dividend_In,
  input  logic [15:0] Divisor_In,
  output logic [15:0] Quotient_Out,
  output logic [15:0] Remainder_Out,
  output logic        Busy_Out,
  output logic        Done_Out,
  output logic        Div_By_Zero_Out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_r;
  logic [15:0] quo_r;
  logic [15:0] rem_r;
  logic [15:0] dvsr_r;
  logic [3:0]  count_r;
  logic        zero_r;

  logic [16:0] trial_s;
  logic [16:0] sum_s;
  logic        fits_s;
  logic [15:0] rem_next_s;
  logic [15:0] quo_next_s;

  // Two-level lookahead: 4-bit groups, group carries resolved from cin.
  function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[16] = gc[4];
    return {c[16], p ^ c[15:0]};
  endfunction

  // Trial subtraction and restore decision for one iteration.
  always_comb begin
    trial_s = {rem_r, quo_r[15]};
    sum_s   = cla16(trial_s[15:0], ~dvsr_r, 1'b1);
    fits_s  = trial_s[16] | sum_s[16];
    if (fits_s) begin
      rem_next_s = sum_s[15:0];
    end else begin
      rem_next_s = trial_s[15:0];
    end
    quo_next_s = {quo_r[14:0], fits_s};
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r         <= ST_IDLE;
      quo_r           <= 16'd0;
      rem_r           <= 16'd0;
      dvsr_r          <= 16'd0;
      count_r         <= 4'd0;
      zero_r          <= 1'b0;
      Quotient_Out    <= 16'd0;
      Remainder_Out   <= 16'd0;
      Busy_Out        <= 1'b0;
      Done_Out        <= 1'b0;
      Div_By_Zero_Out <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          Done_Out <= 1'b0;
          if (Start_In) begin
            quo_r           <= Dividend_In;
            rem_r           <= 16'd0;
            dvsr_r          <= Divisor_In;
            count_r         <= 4'd0;
            zero_r          <= (Divisor_In == 16'd0);
            Busy_Out        <= 1'b1;
            Div_By_Zero_Out <= 1'b0;
            state_r         <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // A zero divisor spends its single busy cycle here without iterating.
          if (zero_r) begin
            Quotient_Out    <= 16'hFFFF;
            Remainder_Out   <= quo_r;
            Div_By_Zero_Out <= 1'b1;
            Done_Out        <= 1'b1;
            Busy_Out        <= 1'b0;
            state_r         <= ST_DONE;
          end else begin
            quo_r   <= quo_next_s;
            rem_r   <= rem_next_s;
            count_r <= count_r + 4'd1;
            if (count_r == 4'd15) begin
              Quotient_Out  <= quo_next_s;
              Remainder_Out <= rem_next_s;
              Done_Out      <= 1'b1;
              Busy_Out      <= 1'b0;
              state_r       <= ST_DONE;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          Busy_Out <= 1'b0;
          Done_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule
